// File: rtl/res_skid_queue_if.sv
// Result-interface bundle between a fixed-latency producer and the skid queue.
// Carries the issue/credit handshake, branch squash, incoming result and
// the writeback-side result plus overflow flag.
interface res_skid_queue_if #(
  parameter int unsigned SQN_W = 7,
  parameter int unsigned TAG_W = 7,
  parameter int unsigned RES_W = 32
);
  typedef struct packed {
    logic             taken;
    logic [SQN_W-1:0] sqN;
  } BranchProv;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [TAG_W-1:0] tagDst;
    logic [SQN_W-1:0] sqN;
    logic             valid;
  } RES_UOp;

  logic      IN_issue;
  logic      OUT_busy;
  BranchProv IN_branch;
  RES_UOp    IN_uop;
  logic      IN_stall;
  RES_UOp    OUT_uop;
  logic      OUT_overflow;

  modport master (
    output IN_issue, IN_branch, IN_uop, IN_stall,
    input  OUT_busy, OUT_uop, OUT_overflow
  );

  modport slave (
    input  IN_issue, IN_branch, IN_uop, IN_stall,
    output OUT_busy, OUT_uop, OUT_overflow
  );
endinterface

// File: rtl/res_skid_queue.sv
// Consumer-side skid queue for fixed-latency execution results.
// Holds results while writeback stalls, squashes entries younger than a
// taken branch, and returns credits to the producer through OUT_busy so
// that every in-flight result is guaranteed a free slot.
module res_skid_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned SQN_W   = 7,
  parameter int unsigned TAG_W   = 7,
  parameter int unsigned RES_W   = 32
) (
  input logic            clk,
  input logic            rst,
  res_skid_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(DEPTH + LATENCY + 1);

  logic             r_valid  [DEPTH];
  logic [SQN_W-1:0] r_sqN    [DEPTH];
  logic [TAG_W-1:0] r_tagDst [DEPTH];
  logic [RES_W-1:0] r_result [DEPTH];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic [LATENCY-1:0] r_hist;
  logic             r_overflow;

  logic          w_occ;
  logic          w_full;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_arr;
  logic          w_push;
  logic          w_drop;
  logic [SW-1:0] w_inflight;
  logic [SW-1:0] w_used;

  // Younger-than-branch test; modular sequence distance so sqN wrap is handled.
  function automatic logic f_squash(input logic [SQN_W-1:0] sqn,
                                    input logic             taken,
                                    input logic [SQN_W-1:0] bsqn);
    logic [SQN_W-1:0] d;
    d = sqn - bsqn;
    return taken && !d[SQN_W-1] && (d != '0);
  endfunction

  // Head visibility, pop/push decisions and overflow detection.
  always_comb begin
    w_occ       = (r_count != '0);
    w_full      = (r_count == CW'(DEPTH));
    w_out_valid = w_occ && r_valid[r_rd] &&
                  !f_squash(r_sqN[r_rd], bus.IN_branch.taken, bus.IN_branch.sqN);
    w_pop       = w_occ && (!bus.IN_stall || !w_out_valid);
    w_arr       = bus.IN_uop.valid &&
                  !f_squash(bus.IN_uop.sqN, bus.IN_branch.taken, bus.IN_branch.sqN);
    w_push      = w_arr && (!w_full || w_pop);
    w_drop      = w_arr && w_full && !w_pop;
  end

  // Credit accounting: occupied slots plus results still in the producer pipe.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_hist[i]);
    end
    w_used = SW'(r_count) + w_inflight;
  end

  assign bus.OUT_busy     = (w_used >= SW'(DEPTH));
  assign bus.OUT_overflow = r_overflow;

  // Head slot drives writeback directly.
  always_comb begin
    bus.OUT_uop        = '0;
    bus.OUT_uop.valid  = w_out_valid;
    bus.OUT_uop.sqN    = r_sqN[r_rd];
    bus.OUT_uop.tagDst = r_tagDst[r_rd];
    bus.OUT_uop.result = r_result[r_rd];
  end

  // Control state: pointers, count, slot valid bits, credit history, overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd       <= '0;
      r_wr       <= '0;
      r_count    <= '0;
      r_hist     <= '0;
      r_overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else begin
      r_hist <= LATENCY'({r_hist, bus.IN_issue});
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_push) begin
        r_wr <= r_wr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      // Later assignments win: a push into the slot being popped (full queue)
      // must leave it valid.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (f_squash(r_sqN[i], bus.IN_branch.taken, bus.IN_branch.sqN)) begin
          r_valid[i] <= 1'b0;
        end
        if (w_pop && (r_rd == PW'(i))) begin
          r_valid[i] <= 1'b0;
        end
        if (w_push && (r_wr == PW'(i))) begin
          r_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Result payload storage; contents are meaningless while the slot is invalid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sqN[r_wr]    <= bus.IN_uop.sqN;
      r_tagDst[r_wr] <= bus.IN_uop.tagDst;
      r_result[r_wr] <= bus.IN_uop.result;
    end
  end
endmodule

// File: doc/res_skid_queue.md
Name: res_skid_queue

Overview:
- Consumer end of the RES_UOp result interface produced by fixed-latency execution units such as the pipelined multiplier.
- Buffers results in a small FIFO when the writeback port stalls, squashes entries younger than a taken branch, and drives a credit-based OUT_busy back to the producer's issue side.
- Credits guarantee that no in-flight result can ever find the queue full.

Parameters:
- DEPTH, 4: number of result slots; power of two, ≥ LATENCY+1.
- LATENCY, 3: cycles from producer accept (IN_issue=1 at edge t) to the result appearing on IN_uop (valid at cycle t+LATENCY).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- IN_issue  input  1  producer accepted a uop this cycle.
- OUT_busy  output  1  producer must not accept a uop this cycle.
- IN_branch  input  BranchProv  taken, sqN of mispredicted branch.
- IN_uop  input  RES_UOp  result from producer.
- IN_stall  input  1  writeback port cannot take OUT_uop this cycle.
- OUT_uop  output  RES_UOp  head result to writeback.
- OUT_overflow  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - count=0, rd/wr pointers=0, all slot valid bits=0.
  - History shift register=0, OUT_overflow=0.
  - OUT_busy=0 the cycle after reset releases.
  - OUT_uop.valid=0; other OUT_uop fields are don't-care while invalid.
- Squash predicate: squash(x) = IN_branch.taken && $signed(x.sqN - IN_branch.sqN) > 0, i.e. strictly younger than the branch. The branch uop itself survives.
- Enqueue:
  - If IN_uop.valid && !squash(IN_uop), write all fields into slot[wr], set the slot valid, and advance wr.
  - Squashed arrivals are discarded and consume no slot.
- Flush of stored entries:
  - Every cycle, any stored slot with squash(slot)=1 has its valid cleared in place.
  - The slot stays allocated until it reaches the head.
- Dequeue (head = slot[rd], occupied when count>0):
  - OUT_uop is combinational from the head slot.
  - OUT_uop.valid = occupied && head.valid && !squash(head), so a same-cycle branch already hides the head.
  - Pop when occupied && (!IN_stall || !OUT_uop.valid). Dead heads drain one per cycle even while stalled.
  - Pop advances rd.
- Counting:
  - count_next = count + push - pop, where push counts allocating arrivals.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle at count=DEPTH is legal; count stays DEPTH.
  - Push and pop in the same cycle at count=0 is not allowed: an arrival is never visible on OUT_uop in the cycle it arrives, so minimum latency IN_uop→OUT_uop is 1 cycle.
- Credit logic:
  - hist is a LATENCY-bit shift register; each cycle it shifts in IN_issue.
  - OUT_busy = (count + popcount(hist)) >= DEPTH, combinational from registered state only, with no dependence on IN_issue, IN_stall or IN_uop.
  - Squashed in-flight uops stay counted until they age out of hist (conservative, never leaks).
- Overflow:
  - If a push is required at count=DEPTH with no pop, the arrival is dropped and OUT_overflow is set.
  - OUT_overflow is cleared only by rst. It must never fire when the producer honours OUT_busy.
- IN_issue while OUT_busy=1 is a producer error. It is still shifted into hist.
- rst mid-operation: all slots and hist are cleared next cycle; in-flight uops arriving after reset are accepted normally.

Test Plan:
1. Pass-through, DEPTH=4, LATENCY=3: single uop tagDst=5, sqN=10, result=0x1234, IN_stall=0 → OUT_uop.valid exactly one cycle after arrival with result=0x1234, tagDst=5; count returns to 0.
2. Stall fill: IN_stall=1, issue every cycle while !OUT_busy → OUT_busy rises after the 4th issue (count+hist=4) and no OUT_overflow. Release the stall → 4 results drain in order, one per cycle, sqN 0,1,2,3.
3. Branch flush: queue holds sqN 3,4,5,6 stalled; IN_branch taken sqN=4 → sqN 5,6 invalidated. After stall release, outputs are sqN 3,4 only; dead slots drain in 2 further cycles; count=0 after 4 pops total.
4. Same-cycle squash: head sqN=9 and IN_branch taken sqN=8 in the same cycle → OUT_uop.valid=0 that cycle. Arrival sqN=12 in the same cycle is not enqueued.
5. Full push/pop: count=4, IN_stall=0, arrival valid → count stays 4, no overflow, order preserved across pointer wrap (wr 3→0).
6. Protocol violation: force an arrival at count=4 with IN_stall=1 → arrival dropped, OUT_overflow=1 and sticky until rst=1; one cycle after rst, OUT_uop.valid=0, OUT_busy=0.
